// File: rtl/between_to_com_pkg.sv
// between_pkg: state encodings, CRC8 constants and helper shared by between_to_com.
// FRAME_BITS is 11 when PARITY_EN is defined (8E1), otherwise 10 (8N1).
package between_pkg;
  typedef enum logic {H_IDLE, H_ACK} hState_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tState_t;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
`ifdef PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  function automatic logic [7:0] crc8Next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ CRC8_POLY : {c[6:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/between_to_com_if.sv
// between_to_com_if: 4-phase parallel link (byte, sent strobe, receive acknowledge).
interface between_to_com_if;
  logic [7:0] tdata;
  logic tsent;
  logic trecieve;
  modport master(output tdata, tsent, input trecieve);
  modport slave(input tdata, tsent, output trecieve);
endinterface

// File: rtl/between_to_com_uart_tx_core.sv
// uart_tx_core: UART serializer, LSB first; inserts even parity when PARITY_EN is defined.
module uart_tx_core
  import between_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  tState_t state, stateNext;
  logic [CW-1:0] baudCnt, baudNext;
  logic [2:0] bitCnt, bitNext;
  logic [7:0] shiftReg, shiftNext;
  logic bitEnd;
`ifdef PARITY_EN
  logic parity, parityNext;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= T_IDLE;
      baudCnt <= '0;
      bitCnt <= '0;
      shiftReg <= '0;
`ifdef PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      baudCnt <= baudNext;
      bitCnt <= bitNext;
      shiftReg <= shiftNext;
`ifdef PARITY_EN
      parity <= parityNext;
`endif
    end
  always_comb begin
    stateNext = state;
    baudNext = baudCnt;
    bitNext = bitCnt;
    shiftNext = shiftReg;
`ifdef PARITY_EN
    parityNext = parity;
`endif
    bitEnd = baudCnt == CW'(CLKS_PER_BIT - 1);
    if (state == T_IDLE) begin
      if (start) begin
        stateNext = T_START;
        baudNext = '0;
        bitNext = '0;
        shiftNext = data;
`ifdef PARITY_EN
        parityNext = ^data;
`endif
      end
    end else if (!bitEnd) baudNext = baudCnt + CW'(1);
    else begin
      baudNext = '0;
      case (state)
        T_START: stateNext = T_DATA;
        T_DATA: begin
          shiftNext = shiftReg >> 1;
          bitNext = bitCnt + 3'd1;
`ifdef PARITY_EN
          if (bitCnt == 3'd7) stateNext = T_PARITY;
`else
          if (bitCnt == 3'd7) stateNext = T_STOP;
`endif
        end
        T_PARITY: stateNext = T_STOP;
        default: stateNext = T_IDLE;
      endcase
    end
  end
  assign ready = state == T_IDLE;
`ifdef PARITY_EN
  assign tx = state == T_START ? 1'b0 : state == T_DATA ? shiftReg[0] : state == T_PARITY ? parity : 1'b1;
`else
  assign tx = state == T_START ? 1'b0 : state == T_DATA ? shiftReg[0] : 1'b1;
`endif
endmodule

// File: rtl/between_to_com.sv
// between_to_com: parallel-link receiver feeding a FIFO drained by a UART transmitter, with running CRC8.
// PARITY_EN (defined) switches the line format from 8N1 to 8E1.
module between_to_com
  import between_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  between_to_com_if.slave    link,
  output logic               tx,
  output logic [7:0]         crc,
  output logic [9:0]         byte_count,
  output logic               fifo_full,
  output logic               busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic sentMeta, sentS;
  hState_t hState, hNext;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [7:0] mem [DEPTH];
  logic fifoEmpty, wrEn, rdEn, txReady;
  assign fifoEmpty = wrPtr == rdPtr;
  assign fifo_full = wrPtr[AW] != rdPtr[AW] && wrPtr[AW-1:0] == rdPtr[AW-1:0];
  assign wrEn = hState == H_IDLE && sentS && !fifo_full;
  assign rdEn = txReady && !fifoEmpty;
  assign link.trecieve = hState == H_ACK;
  assign busy = !fifoEmpty || !txReady;
  always_comb hNext = hState == H_IDLE ? (wrEn ? H_ACK : H_IDLE) : (sentS ? H_ACK : H_IDLE);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sentMeta <= 1'b0;
      sentS <= 1'b0;
      hState <= H_IDLE;
      wrPtr <= '0;
      rdPtr <= '0;
      crc <= CRC8_INIT;
      byte_count <= '0;
    end else begin
      sentMeta <= link.tsent;
      sentS <= sentMeta;
      hState <= hNext;
      if (wrEn) begin
        wrPtr <= wrPtr + PW'(1);
        crc <= crc8Next(crc, link.tdata);
        byte_count <= byte_count + 10'(byte_count != 10'd1023);
      end
      if (rdEn) rdPtr <= rdPtr + PW'(1);
    end
  // storage needs no reset: pointers alone define the contents
  always_ff @(posedge clk)
    if (wrEn) mem[wrPtr[AW-1:0]] <= link.tdata;
  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) txCore (
    .clk(clk),
    .reset(reset),
    .start(rdEn),
    .data(mem[rdPtr[AW-1:0]]),
    .ready(txReady),
    .tx(tx)
  );
endmodule

// File: tb/tb_between_to_com.sv
// tb_between_to_com: scoreboard bench; dutA is 16-deep at 1 clk/bit, dutB is 4-deep at 16 clks/bit.
module tb_between_to_com;
`ifdef PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic txA, txB, fullA, fullB, busyA, busyB;
  logic [7:0] crcA, crcB;
  logic [9:0] cntA, cntB;
  between_to_com_if linkA();
  between_to_com_if linkB();
  between_to_com #(.DEPTH(16), .CLKS_PER_BIT(1)) dutA (
    .clk(clk), .reset(reset), .link(linkA), .tx(txA), .crc(crcA),
    .byte_count(cntA), .fifo_full(fullA), .busy(busyA));
  between_to_com #(.DEPTH(4), .CLKS_PER_BIT(16)) dutB (
    .clk(clk), .reset(reset), .link(linkB), .tx(txB), .crc(crcB),
    .byte_count(cntB), .fifo_full(fullB), .busy(busyB));
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cycle = 0;
  logic [7:0] expA[$], expB[$];
  int cpb[2] = '{1, 16};
  bit act[2];
  int k[2], lastStart[2], gap[2];
  logic [10:0] bits[2];
  logic [7:0] modelCrcA = 8'h00, modelCrcB = 8'h00;
  int modelCntA = 0, modelCntB = 0;

  always @(posedge clk) cycle++;

  function automatic logic [7:0] crcModel(input logic [7:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [10:0] frameOf(input logic [7:0] d);
`ifdef PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // UART receiver model: samples each bit at its centre and compares whole frames
  always @(negedge clk) begin : mon
    logic t;
    int j;
    logic [7:0] e;
    bit have;
    for (int d = 0; d < 2; d++) begin
      t = d == 1 ? txB : txA;
      if (!reset) act[d] = 1'b0;
      else if (!act[d]) begin
        if (!t) begin
          act[d] = 1'b1;
          k[d] = 1;
          bits[d] = '0;
          gap[d] = cycle - lastStart[d];
          lastStart[d] = cycle;
        end
      end else k[d]++;
      if (act[d] && (k[d] - 1) % cpb[d] == cpb[d] / 2) begin
        j = (k[d] - 1) / cpb[d];
        bits[d][j] = t;
        if (j == FB - 1) begin
          act[d] = 1'b0;
          have = d == 1 ? expB.size() > 0 : expA.size() > 0;
          checks++;
          assert (have) else begin
            errors++;
            $error("FAIL unexpected_frame dut%0d got %h expected none", d, bits[d]);
          end
          if (have) begin
            if (d == 1) e = expB.pop_front();
            else e = expA.pop_front();
            checks++;
            assert (bits[d] === frameOf(e)) else begin
              errors++;
              $error("FAIL frame dut%0d got %h expected %h", d, bits[d], frameOf(e));
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic hs(input bit sel, input logic [7:0] d, input bit push, input int maxWait, output int lat);
    int n;
    @(negedge clk);
    if (sel) begin linkB.tdata = d; linkB.tsent = 1'b1; end
    else begin linkA.tdata = d; linkA.tsent = 1'b1; end
    if (push && sel) begin expB.push_back(d); modelCrcB = crcModel(modelCrcB, d); modelCntB++; end
    if (push && !sel) begin expA.push_back(d); modelCrcA = crcModel(modelCrcA, d); modelCntA++; end
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!(sel ? linkB.trecieve : linkA.trecieve) && lat < maxWait);
    check("ack_rise", sel ? linkB.trecieve : linkA.trecieve, 1);
    if (sel) linkB.tsent = 1'b0;
    else linkA.tsent = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((sel ? linkB.trecieve : linkA.trecieve) && n < 20);
    check("ack_fall", sel ? linkB.trecieve : linkA.trecieve, 0);
  endtask

  task automatic waitIdle(input int maxClk);
    int n;
    n = 0;
    while ((busyA || busyB || act[0] || act[1]) && n < maxClk) begin @(negedge clk); n++; end
    check("idle_timeout", {busyA, busyB, act[0], act[1]}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic [7:0] burst[6];
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hE7};
    linkA.tdata = 8'h00; linkA.tsent = 1'b0;
    linkB.tdata = 8'h00; linkB.tsent = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txA", txA, 1);
    check("rst_ackA", linkA.trecieve, 0);
    check("rst_crcA", crcA, 8'h00);
    check("rst_cntA", cntA, 0);
    check("rst_busyA", busyA, 0);
    check("rst_fullA", fullA, 0);
    check("rst_txB", txB, 1);
    check("rst_busyB", busyB, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    hs(0, 8'h55, 1, 20, lat);
    check("ack_latency", lat, 3);
    check("busy_during_tx", busyA, 1);
    check("crc_55", crcA, 8'hAC);
    check("cnt_55", cntA, 1);
    waitIdle(100);

    modelCrcA = 8'h00;
    hs(0, 8'h01, 1, 20, lat);
    check("crc_01", crcA, crcModel(8'hAC, 8'h01));
    hs(0, 8'h02, 1, 20, lat);
    check("crc_01_02", crcA, crcModel(crcModel(8'hAC, 8'h01), 8'h02));
    check("cnt_3", cntA, 3);
    waitIdle(100);
    check("frame_gap", gap[0], FB + 1);

    for (int i = 0; i < 5; i++) begin
      hs(1, burst[i], 1, 20, lat);
      if (i == 3) check("full_after4", fullB, 0);
    end
    check("full_after5", fullB, 1);
    hs(1, burst[5], 1, 600, lat);
    check("backpressure", lat > 20, 1);
    waitIdle(2500);
    check("crcB", crcB, modelCrcB);
    check("cntB", cntB, modelCntB);
    check("emptyB", fullB, 0);

    hs(0, 8'hA3, 0, 20, lat);
    n = 0;
    while (txA && n < 8) begin @(negedge clk); n++; end
    check("midframe_low", txA, 0);
    #2 reset = 1'b0;
    #1;
    check("async_tx", txA, 1);
    check("async_busy", busyA, 0);
    check("async_crc", crcA, 8'h00);
    check("async_cnt", cntA, 0);
    check("async_full", fullA, 0);
    check("async_ack", linkA.trecieve, 0);
    modelCrcA = 8'h00;
    modelCntA = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    hs(0, 8'h3C, 1, 20, lat);
    hs(0, 8'h07, 1, 20, lat);
    hs(0, 8'h03, 1, 20, lat);
    waitIdle(200);
    check("crc_after_reset", crcA, modelCrcA);
    check("cnt_after_reset", cntA, modelCntA);
    check("scoreboard_drainA", expA.size(), 0);
    check("scoreboard_drainB", expB.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
